fifo_ctrl: RTL
==============

# fifo_ctrl

Pointer, arbitration and output-buffer logic that turns the single-port `memoria` RAM into a first-in first-out queue. It sits directly upstream of `memoria` and drives its `data`/`addr`/`we` ports. It consumes `q` with the RAM's one-cycle read latency. Producer and consumer attach through valid/ready handshakes. The single RAM port carries at most one access per cycle: either one write or one read.

## Interface
- `DATA_WIDTH`, 8: word width; must match `memoria`.
- `ADDR_WIDTH`, 8: RAM address width; RAM depth is `2**ADDR_WIDTH`.
- `clk` input 1: clock, rising edge.
- `reset_L` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: producer offers `in_data`.
- `in_data` input `DATA_WIDTH`: word to enqueue.
- `in_ready` output 1: word is accepted on an edge where `in_valid && in_ready`.
- `out_valid` output 1: head word is available on `out_data`.
- `out_data` output `DATA_WIDTH`: head word.
- `out_ready` input 1: consumer takes the head on an edge where `out_valid && out_ready`.
- `mem_data` output `DATA_WIDTH`: to `memoria.data`.
- `mem_addr` output `ADDR_WIDTH`: to `memoria.addr`.
- `mem_we` output 1: to `memoria.we`.
- `mem_q` input `DATA_WIDTH`: from `memoria.q`.
- `level` output `ADDR_WIDTH+2`: total occupancy. Present only with `FIFO_CTRL_LEVEL_EN`.

## Operation
- **State**
  - `wr_ptr` and `rd_ptr`: `ADDR_WIDTH` bits each; wrap modulo `2**ADDR_WIDTH` naturally.
  - `mem_cnt`: `ADDR_WIDTH+1` bits; number of words in RAM.
  - `rd_pend`: 1 bit; a read was issued last cycle.
  - Output buffer: 2 entries, `out_cnt` in 0..2; `out_data` is entry 0.
- **Per-cycle arbitration** (combinational; one of IDLE / RD / WR):
  - `pop = out_valid && out_ready`.
  - RD when `mem_cnt != 0` and `out_cnt + rd_pend - pop <= 1`. Read has priority.
  - WR when RD is not chosen, `in_valid` is high and `mem_cnt < 2**ADDR_WIDTH`.
  - IDLE otherwise.
- `in_ready = (mem_cnt < 2**ADDR_WIDTH) && !RD`. This is combinational and depends on `out_ready`.
- **RD**
  - `mem_addr = rd_ptr`, `mem_we = 0`.
  - `rd_ptr` increments, `mem_cnt` decrements, `rd_pend` is set to 1.
- **WR**
  - `mem_addr = wr_ptr`, `mem_data = in_data`, `mem_we = 1`.
  - `wr_ptr` increments, `mem_cnt` increments.
- **IDLE**: `mem_we = 0`, `mem_addr = rd_ptr`.
- **`rd_pend` completion**: `mem_q` is written into the output buffer tail on the edge ending the following cycle.
- **Output buffer**
  - On a pop, entry 1 shifts to entry 0.
  - A pop and a load on the same edge are both applied.
  - `out_valid = (out_cnt != 0)`.
- **Capacity**: `2**ADDR_WIDTH + 2` words in total.
- **Boundaries**
  - Full RAM (`mem_cnt == 2**ADDR_WIDTH`): `in_ready = 0`.
  - Empty RAM: no RD is issued.
  - Push to an empty queue while the output is idle: WR, then RD, then the word becomes visible.
  - `wr_ptr == rd_ptr` is ambiguous; `mem_cnt` resolves full versus empty.
- **Reset**
  - Pointers, `mem_cnt`, `rd_pend` and `out_cnt` are cleared to 0. `out_data` resets to 0.
  - An in-flight read is discarded. RAM contents are not cleared and are not observable afterwards.

## Timing
- **Reset values**: `in_ready = 1`, `out_valid = 0`, `out_data = 0`, `mem_we = 0`, `mem_addr = 0`, `mem_data = 0`, `level = 0`.
- **Latency into an empty queue**, for `in_valid` accepted at edge E0:
  - WR occupies the cycle ending at E0.
  - RD occupies the cycle ending at E1.
  - `out_valid = 1` after E2.
- **Steady-state throughput**, with `out_ready` held high and a non-empty RAM: 1 read per cycle. Writes stall (`in_ready = 0`) during RD cycles.
- `in_ready` is combinational from `mem_cnt`, `out_cnt`, `rd_pend` and `out_ready`. `out_valid` and `out_data` are registered.

## Configuration
- **`FIFO_CTRL_LEVEL_EN` defined**: `level = mem_cnt + rd_pend + out_cnt`, registered and updated every edge.
- **`FIFO_CTRL_LEVEL_EN` undefined**: the `level` port and its adder are absent. All other behaviour is identical.

## Structure
- **Package `fifo_pkg`**:
  - Arbiter state encoding (IDLE, RD, WR).
  - Output-buffer depth constant `OUT_DEPTH = 2`.
  - Default width constants.
- **Sub-module `fifo_out_buf`**: the 2-entry output buffer with load/pop. `fifo_ctrl` instantiates it.
- **Integration**: a top wrapper, outside this block, instantiates `fifo_ctrl` and `memoria` side by side.

## Test plan
- **Reset sequencing**: assert `reset_L = 0` mid-stream with 5 words queued, then release → `out_valid = 0`, `level = 0`, `in_ready = 1`; the next pushed word `8'hA5` is the first word popped.
- **Single word**: push `8'h3C` with `out_ready = 1` → `out_valid` rises 2 edges after acceptance with `out_data = 8'h3C`; it drops after the pop.
- **Full**: with `ADDR_WIDTH = 2` and `out_ready = 0`, push 0..9 → 6 words accepted (0..5), `in_ready = 0` thereafter; popping returns 0..5 in order.
- **Wrap-around**: with `ADDR_WIDTH = 2`, interleave 20 pushes and pops of an incrementing pattern → output sequence exactly 0..19 and pointers wrap cleanly.
- **Simultaneous push/pop**: queue holds 3 words and both `in_valid` and `out_ready` are high every cycle for 10 cycles → read priority holds (`mem_we = 0` in RD cycles), order is preserved, and `level` stays within 2..4.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and constants for the memoria-backed FIFO controller.
// Optional occupancy output is enabled with FIFO_CTRL_LEVEL_EN (see fifo_ctrl).
package fifo_pkg;

   localparam int DATA_WIDTH_DEF = 8;
   localparam int ADDR_WIDTH_DEF = 8;
   localparam int OUT_DEPTH      = 2;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_RD   = 2'd1,
      ARB_WR   = 2'd2
   } arb_t;

endpackage

// File: rtl/fifo_out_buf.sv
// Two-entry output buffer: holds words already read out of the RAM.
// Entry 0 is the head; a pop and a load on the same edge both apply.
module fifo_out_buf
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] load_data,
   input  logic                  pop,
   output logic [1:0]            cnt,
   output logic [DATA_WIDTH-1:0] head
);

   logic [DATA_WIDTH-1:0] entry0;
   logic [DATA_WIDTH-1:0] entry1;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         entry0 <= '0;
         entry1 <= '0;
         cnt    <= 2'd0;
      end else begin
         case ({pop, load})
            2'b11: begin
               // Shift and refill the freed slot; occupancy is unchanged.
               if (cnt == 2'd1) begin
                  entry0 <= load_data;
               end else begin
                  entry0 <= entry1;
                  entry1 <= load_data;
               end
            end
            2'b10: begin
               entry0 <= entry1;
               cnt    <= cnt - 2'd1;
            end
            2'b01: begin
               if (cnt == 2'd0) begin
                  entry0 <= load_data;
               end else begin
                  entry1 <= load_data;
               end
               if (cnt != 2'(OUT_DEPTH)) begin
                  cnt <= cnt + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign head = entry0;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer/arbitration logic turning the single-port memoria RAM into a FIFO.
// Define FIFO_CTRL_LEVEL_EN to add the registered `level` occupancy port.
//
// state    | meaning
// ARB_IDLE | no RAM access this cycle; address parked on rd_ptr
// ARB_RD   | read head word from RAM into the output buffer (priority)
// ARB_WR   | write accepted in_data word into RAM at wr_ptr
module fifo_ctrl
   import fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] mem_data,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   input  logic [DATA_WIDTH-1:0] mem_q
`ifdef FIFO_CTRL_LEVEL_EN
   ,
   output logic [ADDR_WIDTH+1:0] level
`endif
);

   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   mem_cnt;
   logic [ADDR_WIDTH:0]   mem_cnt_nxt;
   logic                  rd_pend;
   logic [1:0]            out_cnt;
   logic [2:0]            out_occ;
   logic                  pop;
   logic                  mem_full;
   logic                  mem_empty;
   arb_t                  arb;

   assign pop       = out_valid && out_ready;
   // mem_cnt never exceeds the RAM depth, so its MSB alone flags full.
   assign mem_full  = mem_cnt[ADDR_WIDTH];
   assign mem_empty = (mem_cnt == '0);
   // Output-side words committed after this edge, counting an in-flight read.
   assign out_occ   = {1'b0, out_cnt} + {2'b00, rd_pend} - {2'b00, pop};

   always_comb begin
      arb         = ARB_IDLE;
      mem_cnt_nxt = mem_cnt;
      if (!mem_empty && (out_occ <= 3'd1)) begin
         arb         = ARB_RD;
         mem_cnt_nxt = mem_cnt - 1'b1;
      end else if (in_valid && !mem_full) begin
         arb         = ARB_WR;
         mem_cnt_nxt = mem_cnt + 1'b1;
      end
   end

   always_comb begin
      in_ready = !mem_full && (arb != ARB_RD);
      mem_we   = 1'b0;
      mem_addr = rd_ptr;
      mem_data = '0;
      if (arb == ARB_WR) begin
         mem_we   = 1'b1;
         mem_addr = wr_ptr;
         mem_data = in_data;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         mem_cnt <= '0;
         rd_pend <= 1'b0;
      end else begin
         mem_cnt <= mem_cnt_nxt;
         rd_pend <= (arb == ARB_RD);
         if (arb == ARB_RD) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (arb == ARB_WR) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
      end
   end

   fifo_out_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_out_buf (
      .clk       (clk),
      .reset_L   (reset_L),
      .load      (rd_pend),
      .load_data (mem_q),
      .pop       (pop),
      .cnt       (out_cnt),
      .head      (out_data)
   );

   assign out_valid = (out_cnt != 2'd0);

`ifdef FIFO_CTRL_LEVEL_EN
   // Registered from next-state values so it matches the state it sits beside.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         level <= '0;
      end else begin
         level <= (ADDR_WIDTH+2)'(mem_cnt_nxt)
                + (ADDR_WIDTH+2)'(out_occ)
                + (ADDR_WIDTH+2)'(arb == ARB_RD);
      end
   end
`endif

endmodule
